timer_deadline_scheduler: RTL and testbench

//  Multiplexes NR_CHAN software/hardware deadline requesters onto the single platform time base (time_i = mtime).

---
 rtl/timer_deadline_scheduler_if.sv | 14 +
 rtl/timer_deadline_scheduler.sv | 171 +++++++++++++++++
 tb/tb_timer_deadline_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_deadline_scheduler_if.sv
// Arm/cancel request bus between deadline requesters and the scheduler.
// Deadlines are packed per channel, channel c at [c*TIME_WIDTH +: TIME_WIDTH].
interface timer_deadline_scheduler_if #(
  parameter int NR_CHAN    = 4,
  parameter int TIME_WIDTH = 64
);
  logic [NR_CHAN-1:0]            arm_valid;
  logic [NR_CHAN*TIME_WIDTH-1:0] arm_deadline;
  logic [NR_CHAN-1:0]            arm_ready;
  logic [NR_CHAN-1:0]            cancel;

  modport master (output arm_valid, arm_deadline, cancel, input arm_ready);
  modport slave  (input arm_valid, arm_deadline, cancel, output arm_ready);
endinterface

// File: rtl/timer_deadline_scheduler.sv
// Multiplexes NR_CHAN deadline requesters onto one time base: holds one deadline per channel,
// scans sequentially for the earliest pending one and pulses fire_o when time_i reaches it.
module timer_deadline_scheduler #(
  parameter int NR_CHAN    = 4,
  parameter int TIME_WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [TIME_WIDTH-1:0]      time_i,
  timer_deadline_scheduler_if.slave  arm_if,
  output logic [NR_CHAN-1:0]         fire_o,
  output logic [NR_CHAN-1:0]         pending_o,
  output logic                       next_valid_o,
  output logic [TIME_WIDTH-1:0]      next_deadline_o,
  output logic [$clog2(NR_CHAN)-1:0] next_id_o
);
  localparam int IDX_W = $clog2(NR_CHAN);
  localparam logic [IDX_W:0]   CHAN_L   = (IDX_W+1)'(NR_CHAN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_CHAN-1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_FIRE = 2'd3;

  logic [1:0]            r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, r_rr_ptr, r_next_id, r_min_id, w_cand_id, w_gidx;
  logic [NR_CHAN-1:0]    r_pending, w_pending_nxt, r_fire, w_grant;
  logic [TIME_WIDTH-1:0] r_deadline [NR_CHAN];
  logic [TIME_WIDTH-1:0] r_min_dl, w_cand_dl, r_next_deadline;
  logic                  r_min_found, w_cand_found, r_next_valid;
  logic                  w_arm_acc, w_cancel_evt, w_restart, w_to_fire, w_scan_done;
  logic [IDX_W:0]        w_rot;

  // Round-robin arm grant starting at the channel after the last grant; none while firing.
  always_comb begin
    w_arm_acc = 1'b0;
    w_gidx    = '0;
    w_rot     = '0;
    if (r_state != ST_FIRE) begin
      for (int k = 0; k < NR_CHAN; k++) begin
        w_rot = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
        w_rot = (w_rot >= CHAN_L) ? (w_rot - CHAN_L) : w_rot;
        if (!w_arm_acc && arm_if.arm_valid[w_rot[IDX_W-1:0]]) begin
          w_arm_acc = 1'b1;
          w_gidx    = w_rot[IDX_W-1:0];
        end else begin
          w_arm_acc = w_arm_acc;
        end
      end
    end else begin
      w_arm_acc = 1'b0;
    end
    w_grant = w_arm_acc ? (NR_CHAN'(1) << w_gidx) : '0;
  end

  assign arm_if.arm_ready = w_grant;
  assign w_cancel_evt     = (r_state != ST_FIRE) && (|(arm_if.cancel & r_pending));
  assign w_restart        = w_arm_acc | w_cancel_evt;

  // Pending update: cancel is ignored while firing, an arm beats a same-cycle cancel.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_state != ST_FIRE) begin
      w_pending_nxt = (r_pending & ~arm_if.cancel) | w_grant;
    end else begin
      w_pending_nxt = r_pending;
    end
    if (w_to_fire) begin
      w_pending_nxt[r_next_id] = 1'b0;
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
  end

  // Running minimum for the channel under scan; strict < keeps the lowest index on ties.
  always_comb begin
    w_cand_found = r_min_found;
    w_cand_dl    = r_min_dl;
    w_cand_id    = r_min_id;
    if (r_pending[r_idx] && (!r_min_found || (r_deadline[r_idx] < r_min_dl))) begin
      w_cand_found = 1'b1;
      w_cand_dl    = r_deadline[r_idx];
      w_cand_id    = r_idx;
    end else begin
      w_cand_found = r_min_found;
    end
  end

  // Next-state logic; an arm or a cancel of a pending channel always restarts the scan.
  always_comb begin
    w_state_nxt = r_state;
    w_to_fire   = 1'b0;
    w_scan_done = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = w_restart ? ST_SCAN : ST_IDLE;
      ST_SCAN: begin
        if (w_restart) begin
          w_state_nxt = ST_SCAN;
        end else if (r_idx == LAST_IDX) begin
          w_scan_done = 1'b1;
          w_state_nxt = w_cand_found ? ST_WAIT : ST_IDLE;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_WAIT: begin
        if (w_restart) begin
          w_state_nxt = ST_SCAN;
        end else if (time_i >= r_next_deadline) begin
          w_state_nxt = ST_FIRE;
          w_to_fire   = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_FIRE: w_state_nxt = ST_SCAN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, scan bookkeeping, result registers and stored deadlines.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= ST_IDLE;
      r_pending       <= '0;
      r_fire          <= '0;
      r_idx           <= '0;
      r_rr_ptr        <= '0;
      r_min_found     <= 1'b0;
      r_min_dl        <= '0;
      r_min_id        <= '0;
      r_next_valid    <= 1'b0;
      r_next_deadline <= '0;
      r_next_id       <= '0;
      for (int c = 0; c < NR_CHAN; c++) r_deadline[c] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_fire    <= w_to_fire ? (NR_CHAN'(1) << r_next_id) : '0;
      if ((r_state == ST_SCAN) && !w_restart) begin
        r_idx       <= r_idx + IDX_W'(1);
        r_min_found <= w_cand_found;
        r_min_dl    <= w_cand_dl;
        r_min_id    <= w_cand_id;
      end else begin
        r_idx       <= '0;
        r_min_found <= 1'b0;
      end
      if (w_scan_done) begin
        r_next_valid <= w_cand_found;
        if (w_cand_found) begin
          r_next_deadline <= w_cand_dl;
          r_next_id       <= w_cand_id;
        end
      end
      if (w_arm_acc) begin
        r_rr_ptr <= (w_gidx == LAST_IDX) ? '0 : (w_gidx + IDX_W'(1));
      end
      for (int c = 0; c < NR_CHAN; c++) begin
        if (w_grant[c]) r_deadline[c] <= arm_if.arm_deadline[c*TIME_WIDTH +: TIME_WIDTH];
      end
    end
  end

  assign fire_o          = r_fire;
  assign pending_o       = r_pending;
  assign next_valid_o    = r_next_valid;
  assign next_deadline_o = r_next_deadline;
  assign next_id_o       = r_next_id;
endmodule

// File: tb/tb_timer_deadline_scheduler.sv
// Directed bench for timer_deadline_scheduler (NR_CHAN=4, TIME_WIDTH=64) with hand-computed expectations.
module tb_timer_deadline_scheduler;
  logic        clk;
  logic        rst_ni;
  logic [63:0] time_i;
  logic [3:0]  fire_o, pending_o;
  logic        next_valid_o;
  logic [63:0] next_deadline_o;
  logic [1:0]  next_id_o;
  int          n_checks;
  int          n_fail;

  timer_deadline_scheduler_if #(.NR_CHAN(4), .TIME_WIDTH(64)) u_if ();

  timer_deadline_scheduler #(.NR_CHAN(4), .TIME_WIDTH(64)) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .time_i          (time_i),
    .arm_if          (u_if),
    .fire_o          (fire_o),
    .pending_o       (pending_o),
    .next_valid_o    (next_valid_o),
    .next_deadline_o (next_deadline_o),
    .next_id_o       (next_id_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dl(input int c, input logic [63:0] d);
    u_if.arm_deadline[c*64 +: 64] = d;
  endtask

  // Runs up to max_cycles cycles and returns the first nonzero fire_o seen (0 if none).
  task automatic wait_fire(input int max_cycles, output logic [3:0] got);
    got = 4'b0000;
    for (int i = 0; i < max_cycles && got == 4'b0000; i++) begin
      cyc();
      got = fire_o;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_checks++;
      if ({fire_o, pending_o, next_valid_o, next_id_o, u_if.arm_ready} !== 15'd0 || next_deadline_o !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_idle: fire=%b pend=%b nv=%b id=%0d rdy=%b dl=%0d required all zero",
                 fire_o, pending_o, next_valid_o, next_id_o, u_if.arm_ready, next_deadline_o);
      end
    end
  endtask

  task automatic test_past_deadline();
    time_i = 64'd100;
    set_dl(2, 64'd50);
    u_if.arm_valid = 4'b0100;
    #1;
    n_checks++;
    if (u_if.arm_ready !== 4'b0100) begin
      n_fail++; $display("FAIL past_grant: got %b required 0100", u_if.arm_ready);
    end
    cyc();
    u_if.arm_valid = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (fire_o !== 4'b0000) begin
        n_fail++; $display("FAIL past_early_fire t+%0d: got %b required 0000", k, fire_o);
      end
      cyc();
    end
    n_checks++;
    if (fire_o !== 4'b0100) begin
      n_fail++; $display("FAIL past_fire_t6: got %b required 0100", fire_o);
    end
    set_dl(0, 64'hFFFF_FFFF_FFFF_FFFF);
    u_if.arm_valid = 4'b0001;
    #1;
    n_checks++;
    if (u_if.arm_ready !== 4'b0000) begin
      n_fail++; $display("FAIL fire_blocks_arm: got %b required 0000", u_if.arm_ready);
    end
    cyc();
    n_checks++;
    if (fire_o !== 4'b0000 || pending_o[2] !== 1'b0) begin
      n_fail++; $display("FAIL past_after: fire=%b pend=%b required fire 0000 pend[2] 0", fire_o, pending_o);
    end
    n_checks++;
    if (u_if.arm_ready !== 4'b0001) begin
      n_fail++; $display("FAIL arm_after_fire: got %b required 0001", u_if.arm_ready);
    end
    cyc();
    u_if.arm_valid = 4'b0000;
    u_if.cancel = 4'b0001;
    cyc();
    u_if.cancel = 4'b0000;
    repeat (6) cyc();
    n_checks++;
    if (pending_o !== 4'b0000 || next_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL past_cleanup: pend=%b nv=%b required 0000 0", pending_o, next_valid_o);
    end
  endtask

  task automatic test_deadline_order();
    logic [3:0] g;
    time_i = 64'd0;
    set_dl(0, 64'd500);
    set_dl(1, 64'd300);
    set_dl(3, 64'd300);
    u_if.arm_valid = 4'b1011;
    for (int i = 0; i < 6 && u_if.arm_valid != 4'b0000; i++) begin
      #1;
      g = u_if.arm_ready;
      cyc();
      u_if.arm_valid = u_if.arm_valid & ~g;
    end
    n_checks++;
    if (u_if.arm_valid !== 4'b0000) begin
      n_fail++; $display("FAIL order_arms_granted: left %b required 0000", u_if.arm_valid);
    end
    repeat (5) cyc();
    n_checks++;
    if (next_valid_o !== 1'b1 || next_id_o !== 2'd1 || next_deadline_o !== 64'd300) begin
      n_fail++; $display("FAIL order_next: nv=%b id=%0d dl=%0d required 1 1 300", next_valid_o, next_id_o, next_deadline_o);
    end
    time_i = 64'd299;
    wait_fire(4, g);
    n_checks++;
    if (g !== 4'b0000) begin
      n_fail++; $display("FAIL order_at_299: got %b required 0000", g);
    end
    time_i = 64'd300;
    wait_fire(3, g);
    n_checks++;
    if (g !== 4'b0010) begin
      n_fail++; $display("FAIL order_first: got %b required 0010", g);
    end
    wait_fire(10, g);
    n_checks++;
    if (g !== 4'b1000) begin
      n_fail++; $display("FAIL order_second: got %b required 1000", g);
    end
    repeat (5) cyc();
    n_checks++;
    if (next_id_o !== 2'd0 || next_deadline_o !== 64'd500 || pending_o !== 4'b0001) begin
      n_fail++; $display("FAIL order_next3: id=%0d dl=%0d pend=%b required 0 500 0001", next_id_o, next_deadline_o, pending_o);
    end
    wait_fire(3, g);
    n_checks++;
    if (g !== 4'b0000) begin
      n_fail++; $display("FAIL order_hold_300: got %b required 0000", g);
    end
    time_i = 64'd500;
    wait_fire(3, g);
    n_checks++;
    if (g !== 4'b0001) begin
      n_fail++; $display("FAIL order_third: got %b required 0001", g);
    end
    repeat (6) cyc();
    n_checks++;
    if (next_valid_o !== 1'b0 || pending_o !== 4'b0000) begin
      n_fail++; $display("FAIL order_idle: nv=%b pend=%b required 0 0000", next_valid_o, pending_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_b = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rst_ni = 1'b0;
    repeat (2) cyc();
    rst_ni = 1'b1;
    time_i = 64'd0;
    for (int c = 0; c < 4; c++) set_dl(c, 64'hFFFF_FFFF_FFFF_0000);
    u_if.arm_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      g = u_if.arm_ready;
      n_checks++;
      if (g !== exp_a[i]) begin
        n_fail++; $display("FAIL rr_first_%0d: got %b required %b", i, g, exp_a[i]);
      end
      cyc();
      u_if.arm_valid = u_if.arm_valid & ~g;
    end
    u_if.arm_valid = 4'b0010;
    #1;
    n_checks++;
    if (u_if.arm_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rr_single: got %b required 0010", u_if.arm_ready);
    end
    cyc();
    u_if.arm_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      g = u_if.arm_ready;
      n_checks++;
      if (g !== exp_b[i]) begin
        n_fail++; $display("FAIL rr_second_%0d: got %b required %b", i, g, exp_b[i]);
      end
      cyc();
      u_if.arm_valid = u_if.arm_valid & ~g;
    end
    u_if.arm_valid = 4'b0000;
    u_if.cancel = 4'b1111;
    cyc();
    u_if.cancel = 4'b0000;
    repeat (6) cyc();
    n_checks++;
    if (pending_o !== 4'b0000 || next_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rr_cleanup: pend=%b nv=%b required 0000 0", pending_o, next_valid_o);
    end
  endtask

  task automatic test_cancel();
    logic [3:0] g;
    time_i = 64'd0;
    set_dl(1, 64'd1000);
    u_if.arm_valid = 4'b0010;
    cyc();
    u_if.arm_valid = 4'b0000;
    repeat (5) cyc();
    n_checks++;
    if (next_valid_o !== 1'b1 || next_id_o !== 2'd1 || pending_o !== 4'b0010) begin
      n_fail++; $display("FAIL cancel_wait: nv=%b id=%0d pend=%b required 1 1 0010", next_valid_o, next_id_o, pending_o);
    end
    u_if.cancel = 4'b0010;
    cyc();
    u_if.cancel = 4'b0000;
    n_checks++;
    if (pending_o !== 4'b0000 || next_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL cancel_rescan: pend=%b nv=%b required 0000 1", pending_o, next_valid_o);
    end
    wait_fire(8, g);
    n_checks++;
    if (g !== 4'b0000 || next_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL cancel_drop: fire=%b nv=%b required 0000 0", g, next_valid_o);
    end
    time_i = 64'd2000;
    wait_fire(10, g);
    n_checks++;
    if (g !== 4'b0000) begin
      n_fail++; $display("FAIL cancel_no_fire: got %b required 0000", g);
    end
    set_dl(1, 64'd1000000);
    u_if.arm_valid = 4'b0010;
    u_if.cancel = 4'b0010;
    cyc();
    u_if.arm_valid = 4'b0000;
    u_if.cancel = 4'b0000;
    n_checks++;
    if (pending_o !== 4'b0010) begin
      n_fail++; $display("FAIL arm_beats_cancel: pend=%b required 0010", pending_o);
    end
    repeat (6) cyc();
    n_checks++;
    if (next_valid_o !== 1'b1 || next_id_o !== 2'd1 || next_deadline_o !== 64'd1000000) begin
      n_fail++; $display("FAIL arm_cancel_next: nv=%b id=%0d dl=%0d required 1 1 1000000", next_valid_o, next_id_o, next_deadline_o);
    end
    u_if.cancel = 4'b0010;
    cyc();
    u_if.cancel = 4'b0000;
    repeat (6) cyc();
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    time_i = 64'd5;
    set_dl(0, 64'd10);
    u_if.arm_valid = 4'b0001;
    cyc();
    u_if.arm_valid = 4'b0000;
    repeat (5) cyc();
    n_checks++;
    if (next_valid_o !== 1'b1 || next_deadline_o !== 64'd10) begin
      n_fail++; $display("FAIL rstmid_wait: nv=%b dl=%0d required 1 10", next_valid_o, next_deadline_o);
    end
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (pending_o !== 4'b0000 || next_valid_o !== 1'b0 || fire_o !== 4'b0000 || next_deadline_o !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_async: pend=%b nv=%b fire=%b dl=%0d required all zero", pending_o, next_valid_o, fire_o, next_deadline_o);
    end
    repeat (2) cyc();
    rst_ni = 1'b1;
    time_i = 64'd20;
    wait_fire(15, g);
    n_checks++;
    if (g !== 4'b0000 || next_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_fire: fire=%b nv=%b required 0000 0", g, next_valid_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni   = 1'b0;
    time_i   = 64'd0;
    u_if.arm_valid    = 4'b0000;
    u_if.arm_deadline = '0;
    u_if.cancel       = 4'b0000;
    test_reset();
    test_past_deadline();
    test_deadline_order();
    test_round_robin();
    test_cancel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
